vga_fb_reader: RTL

Frame-buffer prefetch stage for the VGA path. It issues sequential byte reads to the SRAM controller through its trig/rw/addr/done handshake and buffers the returned pixels in a small show-ahead FIFO. The VGA timing generator drains that FIFO one byte per active pixel. It sits between the VGA timing generator and the SRAM controller, and is the only SRAM read master during scan-out.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_fb_reader_if.sv | 15 +
 rtl/vga_pix_fifo.sv | 51 +++++
 rtl/vga_fb_reader.sv | 88 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the frame-buffer fetch FSM encoding.
package vga_pkg;

   localparam int unsigned H_ACTIVE  = 640;
   localparam int unsigned V_ACTIVE  = 480;
   localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
   localparam int unsigned SRAM_AW   = 19;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_REQ       = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      REQ       = ST_REQ,
      WAIT_BUSY = ST_WAIT_BUSY,
      WAIT_DONE = ST_WAIT_DONE
   } fetch_state_t;

endpackage

// File: rtl/vga_fb_reader_if.sv
// SRAM controller handshake seen by the frame-buffer reader (master) and the controller (slave).
interface vga_fb_reader_if;
   import vga_pkg::*;

   logic               sram_trig;
   logic               sram_rw;
   logic [SRAM_AW-1:0] sram_addr;
   logic [7:0]         sram_rdata;
   logic               sram_done;

   modport master (output sram_trig, sram_rw, sram_addr,
                   input  sram_rdata, sram_done);
   modport slave  (input  sram_trig, sram_rw, sram_addr,
                   output sram_rdata, sram_done);
endinterface

// File: rtl/vga_pix_fifo.sv
// Synchronous show-ahead pixel FIFO; head reads 0 when empty, flush wins over push/pop.
module vga_pix_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/vga_fb_reader.sv
// Scan-out prefetch: sequential single-byte SRAM reads feeding a show-ahead pixel FIFO.
module vga_fb_reader #(
   parameter int unsigned                    FRAME_PIX  = vga_pkg::FRAME_PIX,
   parameter logic [vga_pkg::SRAM_AW-1:0]    BASE_ADDR  = '0,
   parameter int unsigned                    FIFO_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_start,
   input  logic            pix_rd,
   output logic [7:0]      pix_data,
   output logic            pix_valid,
   output logic            underflow,
   vga_fb_reader_if.master sram
);
   import vga_pkg::*;

   localparam int unsigned CW = $clog2(FRAME_PIX + 1);
   localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state, state_nxt;
   logic [CW-1:0] fetch_cnt;
   logic          discard;
   logic [FW-1:0] fifo_count;
   logic          fifo_empty, fifo_full;
   logic          capture, push, want_fetch;

   assign capture    = (state == WAIT_DONE) && sram.sram_done;
   // A flush in the capture cycle also drops the byte: it belongs to the old frame.
   assign push       = capture && !discard && !frame_start && !fifo_full;
   assign want_fetch = (fetch_cnt < CW'(FRAME_PIX)) && (fifo_count < FW'(FIFO_DEPTH));

   assign sram.sram_trig = (state == REQ);
   assign sram.sram_rw   = 1'b1;
   assign sram.sram_addr = BASE_ADDR + SRAM_AW'(fetch_cnt);
   assign pix_valid      = !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         // frame_start restarts at address 0 with an empty FIFO, so fetch immediately
         IDLE:      if (frame_start || want_fetch) state_nxt = REQ;
         REQ:       state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!sram.sram_done) state_nxt = WAIT_DONE;
         WAIT_DONE: if (sram.sram_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         discard   <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (frame_start) fetch_cnt <= '0;
         else if (push)   fetch_cnt <= fetch_cnt + CW'(1);

         if (state_nxt == IDLE)                  discard <= 1'b0;
         else if (frame_start && state != IDLE)  discard <= 1'b1;

         if (frame_start)              underflow <= 1'b0;
         else if (pix_rd && fifo_empty) underflow <= 1'b1;
      end
   end

   vga_pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pix_rd),
      .flush (frame_start),
      .wdata (sram.sram_rdata),
      .rdata (pix_data),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
